// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the IF/MEM single-port memory arbiter.
// Pure declarations: no latency, no flow control.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 32;
  localparam int MEM_ARB_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// Clear beats increment; full holds until cleared, no backpressure.
module mem_arb_starve_ctr #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         full
);

  assign full = (cnt == W'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-port memory, one outstanding access; issue 1 cycle after request, completion passed through combinationally.
// Requesters stall on req & ~rvalid; data wins unless MEM_ARB_STARVE_GUARD_EN forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       sel_if, sel_dm;
  logic       if_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_full;

  // Any cycle without a pending fetch breaks the "consecutive" run.
  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (~if_req | sel_if),
    .inc   (sel_dm & if_req),
    .cnt   (starve_cnt),
    .full  (starve_full)
  );

  assign if_force = starve_full & if_req;
`else
  assign if_force = 1'b0;
`endif

  always_comb begin
    sel_if = 1'b0;
    sel_dm = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (if_req && (!dm_req || if_force)) begin
        sel_if = 1'b1;
      end else if (dm_req) begin
        sel_dm = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_if) begin
          state_d = ARB_WAIT;
          owner_d = OWN_IF;
        end else if (sel_dm) begin
          state_d = ARB_WAIT;
          owner_d = OWN_DM;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Completion is gated by WAIT so a late or spurious mem_rvalid never leaks out.
  always_comb begin
    if_rvalid = (state_q == ARB_WAIT) && (owner_q == OWN_IF) && mem_rvalid;
    dm_rvalid = (state_q == ARB_WAIT) && (owner_q == OWN_DM) && mem_rvalid;
    if_rdata  = (owner_q == OWN_IF) ? mem_rdata : '0;
    dm_rdata  = (owner_q == OWN_DM) ? mem_rdata : '0;
  end

  // Command register: strobes last one cycle, address/data hold until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
    end else begin
      mem_req <= sel_if | sel_dm;
      if_gnt  <= sel_if;
      dm_gnt  <= sel_dm;
      if (sel_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr & ALIGN_MASK;
        mem_wdata <= '0;
      end else if (sel_dm) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr & ALIGN_MASK;
        mem_wdata <= dm_wdata;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch (IF) and data-access (MEM) requesters onto one shared single-port memory. It allows one outstanding transaction at a time. Data accesses have priority over fetches, and an optional starvation guard bounds how long a fetch can wait. It sits between the CPU pipeline stages and the unified memory. Requesters stall on their own `*_req & ~*_rvalid`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch is pending (guard only).
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_rvalid`.
- `if_addr`  in  ADDR_W  fetch byte address; stable while `if_req`.
- `if_gnt`  out  1  one-cycle pulse when the fetch is issued to memory.
- `if_rvalid`  out  1  fetch completion pulse.
- `if_rdata`  out  DATA_W  fetch data; valid with `if_rvalid`.
- `dm_req`  in  1  data request; held high until `dm_rvalid`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_gnt`  out  1  one-cycle issue pulse.
- `dm_rvalid`  out  1  data completion pulse. Fires for writes too, as an ack.
- `dm_rdata`  out  DATA_W  read data; don't-care for writes.
- `mem_req`  out  1  one-cycle memory command strobe.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  word-aligned address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rvalid`  in  1  memory completion; arrives 1 or more cycles after `mem_req`.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - WAIT: transaction outstanding; owner register = IF or DM.
- IDLE arbitration:
  - `dm_req` wins over `if_req`.
  - Guard exception: if `starve_cnt == STARVE_MAX` and `if_req` is high, IF wins.
  - No request: stay in IDLE.
- On selection: register the command and go to WAIT.
  - Next cycle: `mem_req=1` and the winner's `*_gnt=1`, both for exactly one cycle.
  - `mem_addr = addr & ~3` (low 2 bits forced to 0).
  - `mem_we` = `dm_we` for DM; 0 for IF.
  - `mem_wdata` = `dm_wdata` for DM; 0 for IF.
- In WAIT, `mem_rvalid` completes the transaction:
  - Same cycle, combinationally: owner's `*_rvalid=1`; `*_rdata=mem_rdata`.
  - Next state: IDLE.
  - The non-owner's `rvalid` stays 0.
- `mem_rvalid` in IDLE (spurious or late) is ignored; no `*_rvalid` is generated.
- `*_rdata` is driven from `mem_rdata` whenever the owner matches; it is only meaningful with `*_rvalid`.
- Reset mid-WAIT: the transaction is abandoned, the FSM goes to IDLE, and the owner is cleared. A subsequent `mem_rvalid` is ignored as above.
- `starve_cnt`, width `$clog2(STARVE_MAX+1)`:
  - Increments (saturating) on each DM grant while `if_req` is high.
  - Clears on an IF grant, or whenever `if_req` is low.

## Timing
- Reset values: `mem_req`, `mem_we`, `if_gnt`, `dm_gnt`, `if_rvalid`, `dm_rvalid` = 0. `mem_addr`, `mem_wdata` = 0. State = IDLE, owner = none, `starve_cnt` = 0.
- Request seen in IDLE at cycle N → `mem_req`/`gnt` at N+1.
- `mem_rvalid` at cycle M → owner `rvalid` at M (0 extra latency) → IDLE at M+1 → next `mem_req` no earlier than M+2.
- Minimum transaction, `mem_rvalid` one cycle after `mem_req`: 3 cycles from request to rvalid.
- Simultaneous `if_req` and `dm_req` in IDLE resolve by the priority rule only. Requests arriving during WAIT wait for the next IDLE.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined: `starve_cnt` is present and IF is forced to win after `STARVE_MAX` consecutive DM grants with IF pending.
- Undefined: strict DM priority. `starve_cnt` and `STARVE_MAX` usage are removed, and a continuously held `dm_req` starves IF indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (`ARB_IDLE`, `ARB_WAIT`).
  - Owner encoding (`OWN_NONE`, `OWN_IF`, `OWN_DM`).
  - Shared `ADDR_W`/`DATA_W` defaults.
- Sub-module `mem_arb_starve_ctr`: saturating counter with clear/inc/full. Instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- **Single fetch.** `if_req` with `if_addr=0x10` at N; memory returns `0xDEADBEEF` at N+3. Required: `mem_req`, `if_gnt`, `mem_addr=0x10`, `mem_we=0` at N+1; `if_rvalid=1` and `if_rdata=0xDEADBEEF` at N+3; `dm_rvalid=0` throughout.
- **Collision.** `if_req` and `dm_req` (read `0x200`) both high at N. Required: DM issued at N+1. Once DM rvalid arrives at M, IF is issued (`if_gnt`) at M+2.
- **Write alignment.** `dm_we=1`, `dm_addr=0x103`, `dm_wdata=0x12345678`. Required: `mem_addr=0x100`, `mem_we=1`, `mem_wdata=0x12345678`; `dm_rvalid` pulses on the ack.
- **Starvation.** `dm_req` and `if_req` held high, `STARVE_MAX=4`, 1-cycle memory.
  - With the macro: exactly 4 DM grants, then `if_gnt`, then DM resumes.
  - Without the macro: zero `if_gnt` over 50 transactions.
- **Reset mid-WAIT.** Issue a fetch, assert `reset` before `mem_rvalid`, deassert it, then pulse `mem_rvalid`. Required: no `if_rvalid`, all outputs 0, FSM in IDLE.
- **Spurious rvalid.** `mem_rvalid` pulsed in IDLE with no requests. Required: no `*_rvalid`, no `mem_req`.
